// File: rtl/seq_frame_sched_if.sv
// Frame request / result bus between two parallel requesters and the scheduler.
interface seq_frame_sched_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [2:0]       mstate;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, done0, done1, result, busy, mstate
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, done0, done1, result, busy, mstate
    );
endinterface

// File: rtl/seq_frame_sched.sv
// Round-robin scheduler feeding parallel frames LSB-first through a shared
// 3-bit serial Mealy machine and returning the collected output word.
module seq_frame_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_frame_sched_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt;
    logic [2:0]       mst;
    logic             owner;
    logic             ptr;
    logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, busy_nxt;
    logic             any_req_c;
    logic             pick1_c;
    logic             y_c;
    logic [2:0]       mst_nxt_c;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    assign any_req_c = bus.req0 | bus.req1;
    assign pick1_c   = bus.req1 & (~bus.req0 | ~ptr);

    // Serial machine: Mealy output and next state from the pre-edge state and current bit.
    always_comb begin
        logic a, b, c, x;
        a = mst[2];
        b = mst[1];
        c = mst[0];
        x = shreg[0];
        y_c          = (~a & x) | (~a & ~b & c);
        mst_nxt_c[2] = ~a & ~b & x;
        mst_nxt_c[1] = ((((~c & ~x) | a) & ~b)) | (~(c ^ x) & b);
        mst_nxt_c[0] = ((((a & x) | (~a & ~b & ~x)) & ~c)) | (~x & c);
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req_c) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Controller outputs: next values of the registered pulse and busy flags.
    always_comb begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        busy_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req_c) begin
                    gnt0_nxt = ~pick1_c;
                    gnt1_nxt = pick1_c;
                    busy_nxt = 1'b1;
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                if (cnt == LAST) begin
                    done0_nxt = ~owner;
                    done1_nxt = owner;
                end
            end
            default: ;
        endcase
    end

    // Datapath: frame capture, serial shifting, result collection and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            result_q <= '0;
            cnt      <= '0;
            mst      <= 3'b000;
            owner    <= 1'b0;
            ptr      <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gnt0_q  <= gnt0_nxt;
            gnt1_q  <= gnt1_nxt;
            done0_q <= done0_nxt;
            done1_q <= done1_nxt;
            busy_q  <= busy_nxt;
            if (state == IDLE && any_req_c) begin
                shreg <= pick1_c ? bus.data1 : bus.data0;
                owner <= pick1_c;
                ptr   <= pick1_c;
                cnt   <= '0;
                mst   <= 3'b000;
            end else if (state == SHIFT) begin
                result_q[cnt] <= y_c;
                mst           <= mst_nxt_c;
                shreg         <= shreg >> 1;
                cnt           <= cnt + CW'(1);
            end
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;
    assign bus.mstate = mst;
endmodule

// File: tb/tb_seq_frame_sched.sv
// Bench for seq_frame_sched: frame-level reference model plus directed and random traffic.
module tb_seq_frame_sched;
    localparam int unsigned W  = 8;
    localparam int          WI = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    seq_frame_sched_if #(.WIDTH(W)) bus ();
    seq_frame_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // One step of the serial machine from its boolean equations.
    function automatic logic [2:0] mstep(input logic [2:0] s, input logic x, output logic y);
        logic a, b, c;
        logic [2:0] n;
        a = s[2]; b = s[1]; c = s[0];
        y    = (~a & x) | (~a & ~b & c);
        n[2] = ~a & ~b & x;
        n[1] = (((~c & ~x) | a) & ~b) | (~(c ^ x) & b);
        n[0] = (((a & x) | (~a & ~b & ~x)) & ~c) | (~x & c);
        return n;
    endfunction

    // Whole-frame run from state 000: {final state, result word}.
    function automatic logic [W+2:0] frame_run(input logic [W-1:0] d);
        logic [2:0]   s;
        logic [W-1:0] r;
        logic         yb;
        s = 3'b000;
        r = '0;
        for (int i = 0; i < WI; i++) begin
            s    = mstep(s, d[i], yb);
            r[i] = yb;
        end
        return {s, r};
    endfunction

    // Reference model: m_phase = -1 idle, 0..W-1 shifting bit m_phase, W = done cycle.
    int           m_phase = -1;
    logic         m_ptr   = 1'b1;
    logic         m_owner = 1'b0;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] m_old   = '0;
    logic [W-1:0] m_new   = '0;
    logic [2:0]   m_ms    = 3'b000;
    logic [2:0]   m_trace [0:W];

    always @(posedge clk or posedge rst) begin : model
        logic         w;
        logic [W-1:0] d;
        logic [W-1:0] nr;
        logic [2:0]   s;
        logic         yb;
        if (rst) begin
            m_phase <= -1;
            m_ptr   <= 1'b1;
            m_res   <= '0;
            m_ms    <= 3'b000;
        end else if (m_phase < 0) begin
            if (bus.req0 || bus.req1) begin
                w = (bus.req0 && bus.req1) ? ~m_ptr : bus.req1;
                d = w ? bus.data1 : bus.data0;
                s = 3'b000;
                nr = '0;
                for (int i = 0; i < WI; i++) begin
                    m_trace[i] <= s;
                    s = mstep(s, d[i], yb);
                    nr[i] = yb;
                end
                m_trace[W] <= s;
                m_new   <= nr;
                m_old   <= m_res;
                m_owner <= w;
                m_ptr   <= w;
                m_phase <= 0;
            end
        end else if (m_phase == WI) begin
            m_phase <= -1;
            m_res   <= m_new;
            m_ms    <= m_trace[W];
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : cmp
        logic [W-1:0] er;
        logic [2:0]   ems;
        if (m_phase < 0) begin
            er  = m_res;
            ems = m_ms;
        end else begin
            for (int i = 0; i < WI; i++) er[i] = (i < m_phase) ? m_new[i] : m_old[i];
            ems = m_trace[m_phase];
        end
        chk("gnt0",   32'(bus.gnt0),   32'(m_phase == 0 && !m_owner));
        chk("gnt1",   32'(bus.gnt1),   32'(m_phase == 0 && m_owner));
        chk("done0",  32'(bus.done0),  32'(m_phase == WI && !m_owner));
        chk("done1",  32'(bus.done1),  32'(m_phase == WI && m_owner));
        chk("busy",   32'(bus.busy),   32'(m_phase >= 0));
        chk("mstate", 32'(bus.mstate), 32'(ems));
        chk("result", 32'(bus.result), 32'(er));
    end

    // Grant log for spacing/alternation checks.
    logic rec = 1'b0;
    int   gq_who[$];
    int   gq_cyc[$];
    always @(negedge clk) begin
        if (rec && (bus.gnt0 || bus.gnt1)) begin
            gq_who.push_back(int'(bus.gnt1));
            gq_cyc.push_back(cyc);
        end
    end

    task automatic set_req(input int who, input logic v);
        if (who == 0) bus.req0 = v;
        else          bus.req1 = v;
    endtask

    task automatic set_data(input int who, input logic [W-1:0] d);
        if (who == 0) bus.data0 = d;
        else          bus.data1 = d;
    endtask

    function automatic logic gnt_of(input int who);
        return (who == 0) ? bus.gnt0 : bus.gnt1;
    endfunction

    function automatic logic done_of(input int who);
        return (who == 0) ? bus.done0 : bus.done1;
    endfunction

    // Single frame from an idle scheduler; called just after a falling edge.
    task automatic run_frame(input int who, input logic [W-1:0] d,
                             input logic [W-1:0] exp_res, input logic [2:0] exp_ms);
        set_data(who, d);
        set_req(who, 1'b1);
        @(negedge clk);
        chk("frame_gnt", 32'(gnt_of(who)), 32'd1);
        set_req(who, 1'b0);
        repeat (W) @(negedge clk);
        chk("frame_done",   32'(done_of(who)), 32'd1);
        chk("frame_result", 32'(bus.result),   32'(exp_res));
        chk("frame_mstate", 32'(bus.mstate),   32'(exp_ms));
        @(negedge clk);
    endtask

    initial begin : stim
        logic [2:0] s;
        logic       yb;
        logic [2:0] exp_tr [4];
        int         n;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.data0 = '0;  bus.data1 = '0;

        // Pin the model's machine against hand-derived values.
        chk("model_00", 32'(frame_run(8'h00)), 32'({3'b001, 8'hFC}));
        chk("model_FF", 32'(frame_run(8'hFF)), 32'({3'b000, 8'hDD}));
        exp_tr = '{3'b000, 3'b100, 3'b011, 3'b010};
        s = 3'b000;
        for (int i = 0; i < 8; i++) begin
            chk("model_trace", 32'(s), 32'(exp_tr[i % 4]));
            s = mstep(s, 1'b1, yb);
        end

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_mstate", 32'(bus.mstate), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from each requester.
        run_frame(0, 8'h00, 8'hFC, 3'b001);
        run_frame(1, 8'hFF, 8'hDD, 3'b000);

        // Request arriving while requester 0 is shifting waits for the next idle cycle.
        set_data(0, 8'h00); set_req(0, 1'b1);
        @(negedge clk);
        chk("ov_gnt0", 32'(bus.gnt0), 32'd1);
        set_req(0, 1'b0);
        repeat (3) @(negedge clk);
        set_data(1, 8'hFF); set_req(1, 1'b1);
        repeat (W - 3) @(negedge clk);
        chk("ov_done0",  32'(bus.done0),  32'd1);
        chk("ov_result", 32'(bus.result), 32'(8'hFC));
        n = 0;
        while (!bus.gnt1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("ov_gnt1_delay", 32'(n), 32'd2);
        set_req(1, 1'b0);
        repeat (W) @(negedge clk);
        chk("ov_done1",  32'(bus.done1),  32'd1);
        chk("ov_result1", 32'(bus.result), 32'(8'hDD));
        @(negedge clk);

        // Both requesters held from reset: alternating grants every W+2 cycles.
        #2 rst = 1'b1;
        set_data(0, 8'h00); set_data(1, 8'h00);
        set_req(0, 1'b1);   set_req(1, 1'b1);
        rec = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        rec = 1'b0;
        set_req(0, 1'b0); set_req(1, 1'b0);
        repeat (12) @(negedge clk);
        chk("rr_count", 32'(gq_who.size() >= 4), 32'd1);
        for (int i = 0; i < gq_who.size(); i++) begin
            chk("rr_owner", 32'(gq_who[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'(W + 2));
        end

        // Asynchronous reset in the middle of a frame.
        set_data(0, 8'hFF); set_req(0, 1'b1);
        @(negedge clk);
        set_req(0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt0",   32'(bus.gnt0),   32'd0);
        chk("arst_gnt1",   32'(bus.gnt1),   32'd0);
        chk("arst_done0",  32'(bus.done0),  32'd0);
        chk("arst_done1",  32'(bus.done1),  32'd0);
        chk("arst_busy",   32'(bus.busy),   32'd0);
        chk("arst_mstate", 32'(bus.mstate), 32'd0);
        chk("arst_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        run_frame(0, 8'hFF, 8'hDD, 3'b000);

        // Requester 0 raises and withdraws while busy: never granted.
        set_data(1, 8'h00); set_req(1, 1'b1);
        @(negedge clk);
        set_req(1, 1'b0);
        repeat (2) @(negedge clk);
        set_data(0, 8'hAA); set_req(0, 1'b1);
        repeat (3) @(negedge clk);
        set_req(0, 1'b0);
        repeat (W - 5) @(negedge clk);
        chk("wd_done1",  32'(bus.done1),  32'd1);
        chk("wd_result", 32'(bus.result), 32'(8'hFC));
        repeat (4) @(negedge clk);
        chk("wd_nogrant", 32'(bus.gnt0),  32'd0);
        chk("wd_hold",    32'(bus.result), 32'(8'hFC));

        // Random traffic following the requester protocol, with occasional withdrawals.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                logic cur;
                cur = (r == 0) ? bus.req0 : bus.req1;
                if (cur && m_phase == 0 && m_owner == r[0]) begin
                    set_req(r, 1'b0);
                end else if (!cur && $urandom_range(3) == 0) begin
                    set_data(r, W'($urandom));
                    set_req(r, 1'b1);
                end else if (cur && m_phase > 0 && $urandom_range(15) == 0) begin
                    set_req(r, 1'b0);
                end
            end
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
